// File: rtl/quad_video_timing_pkg.sv
// Shared timing sets, quadrant indices, colours and the alignment-pipeline payload
// for the quad video timing path.
package quad_video_timing_pkg;

  localparam int HD720_H_ACTIVE = 1280;
  localparam int HD720_H_FP     = 110;
  localparam int HD720_H_SYNC   = 40;
  localparam int HD720_H_BP     = 220;
  localparam int HD720_V_ACTIVE = 720;
  localparam int HD720_V_FP     = 5;
  localparam int HD720_V_SYNC   = 5;
  localparam int HD720_V_BP     = 20;

  localparam logic [1:0] Q_TL = 2'd0;
  localparam logic [1:0] Q_TR = 2'd1;
  localparam logic [1:0] Q_BL = 2'd2;
  localparam logic [1:0] Q_BR = 2'd3;

  localparam logic [23:0] RGB_BLACK = 24'h000000;

  // Everything that must travel alongside a pixel while its FIFO read is in flight.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       fill;
    logic [1:0] q;
  } dly_t;

  function automatic logic [1:0] quad_of(input logic bottom, input logic right);
    logic [1:0] q;
    unique case ({bottom, right})
      2'b00:   q = Q_TL;
      2'b01:   q = Q_TR;
      2'b10:   q = Q_BL;
      default: q = Q_BR;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/quad_video_timing_if.sv
// FIFO read side and VGA output side of the quad compositor, bundled as one port.
interface quad_video_timing_if;
  logic [3:0]       rd_empty;
  logic [3:0][23:0] rd_data;
  logic [3:0]       rd_req;
  logic             frame_start;
  logic [3:0]       underflow;
  logic             vga_hs;
  logic             vga_vs;
  logic             vga_de;
  logic [23:0]      vga_rgb;

  modport master (
    input  rd_empty, rd_data,
    output rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb
  );

  modport slave (
    output rd_empty, rd_data,
    input  rd_req, frame_start, underflow, vga_hs, vga_vs, vga_de, vga_rgb
  );
endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH register pipeline with synchronous clear to a programmable idle word.
module vga_sync_delay #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) stage_reg[gi] <= CLR_VAL;
          else     stage_reg[gi] <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) stage_reg[gi] <= CLR_VAL;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/quad_video_timing.sv
// Raster counter plus 2x2 quadrant compositor: reads one of four FIFOs per active pixel
// and emits hs/vs/de/rgb aligned RD_LAT+1 cycles behind the counters.
module quad_video_timing
  import quad_video_timing_pkg::*;
#(
  parameter int          H_ACTIVE = HD720_H_ACTIVE,
  parameter int          H_FP     = HD720_H_FP,
  parameter int          H_SYNC   = HD720_H_SYNC,
  parameter int          H_BP     = HD720_H_BP,
  parameter int          V_ACTIVE = HD720_V_ACTIVE,
  parameter int          V_FP     = HD720_V_FP,
  parameter int          V_SYNC   = HD720_V_SYNC,
  parameter int          V_BP     = HD720_V_BP,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int          RD_LAT   = 1,
  parameter logic [23:0] FILL_RGB = RGB_BLACK
) (
  input logic                 clk,
  input logic                 rst,
  quad_video_timing_if.master bus
);

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_HALF = 12'(H_ACTIVE / 2);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_HALF = 12'(V_ACTIVE / 2);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam dly_t BLANK = '{hs: ~HS_POL, vs: ~VS_POL, act: 1'b0, fill: 1'b0, q: Q_TL};

  logic [11:0] h_cnt_reg, v_cnt_reg;
  logic        act, hs_raw, vs_raw, fill;
  logic [1:0]  quad;
  logic [3:0]  rd_req;
  dly_t        dly_in, dly_out;
  logic [$bits(dly_t)-1:0] dly_out_bits;

  logic        hs_reg, vs_reg, de_reg, frame_start_reg;
  logic [23:0] rgb_reg;
  logic [3:0]  underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 12'd1;
    end
  end

  // An empty FIFO on an active pixel skips the read but the raster keeps moving,
  // so a starved channel never shifts the picture.
  always_comb begin
    act    = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    hs_raw = (h_cnt_reg >= HS_BEG && h_cnt_reg < HS_END) ? HS_POL : ~HS_POL;
    vs_raw = (v_cnt_reg >= VS_BEG && v_cnt_reg < VS_END) ? VS_POL : ~VS_POL;
    quad   = quad_of(v_cnt_reg >= V_HALF, h_cnt_reg >= H_HALF);
    fill   = act && bus.rd_empty[quad];
    rd_req = '0;
    if (act && !fill && !rst) rd_req[quad] = 1'b1;
    dly_in = '{hs: hs_raw, vs: vs_raw, act: act, fill: fill, q: quad};
  end

  vga_sync_delay #(
    .DEPTH   (RD_LAT),
    .WIDTH   ($bits(dly_t)),
    .CLR_VAL (BLANK)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out_bits)
  );

  assign dly_out = dly_t'(dly_out_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_reg  <= ~HS_POL;
      vs_reg  <= ~VS_POL;
      de_reg  <= 1'b0;
      rgb_reg <= '0;
    end else begin
      hs_reg <= dly_out.hs;
      vs_reg <= dly_out.vs;
      de_reg <= dly_out.act;
      if (!dly_out.act)     rgb_reg <= '0;
      else if (dly_out.fill) rgb_reg <= FILL_RGB;
      else                   rgb_reg <= bus.rd_data[dly_out.q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_reg   <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      if (fill) underflow_reg[quad] <= 1'b1;
      frame_start_reg <= (h_cnt_reg == 12'd0) && (v_cnt_reg == V_LAST);
    end
  end

  assign bus.rd_req      = rd_req;
  assign bus.underflow   = underflow_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.vga_hs      = hs_reg;
  assign bus.vga_vs      = vs_reg;
  assign bus.vga_de      = de_reg;
  assign bus.vga_rgb     = rgb_reg;

endmodule
